// File: rtl/slot_freelist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slot_freelist_pkg
//  Purpose  : Shared constants and helpers for the slot free-list allocator.
//  Revision : 1.0  initial release
// ============================================================================
package slot_freelist_pkg;

    // Legal slot-count range for the allocator.
    localparam int DW_MIN = 2;
    localparam int DW_MAX = 128;

    // Ceiling log2, used to size index and counter fields.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_freelist_if.sv
`default_nettype none
// ============================================================================
//  Module   : slot_freelist_if
//  Purpose  : Allocate / free / flush handshake and status bundle of the
//             slot free-list allocator.
//  Revision : 1.0  initial release
// ============================================================================
interface slot_freelist_if #(
    parameter int CW = 2,
    parameter int DW = 2 ** CW
);
    logic          alloc_valid_i;
    logic          alloc_ready_o;
    logic [CW-1:0] alloc_idx_o;
    logic          free_valid_i;
    logic [CW-1:0] free_idx_i;
    logic          flush_i;
    logic [DW-1:0] busy_o;
    logic [CW:0]   cnt_o;
    logic          full_o;
    logic          empty_o;
    logic          err_o;

    // Allocator side
    modport slave (
        input  alloc_valid_i, free_valid_i, free_idx_i, flush_i,
        output alloc_ready_o, alloc_idx_o, busy_o, cnt_o, full_o, empty_o, err_o
    );

    // Requester side
    modport master (
        output alloc_valid_i, free_valid_i, free_idx_i, flush_i,
        input  alloc_ready_o, alloc_idx_o, busy_o, cnt_o, full_o, empty_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/slot_freelist_idx2oh.sv
`default_nettype none
// ============================================================================
//  Module   : idx2oh
//  Purpose  : Combinational binary index to one-hot decoder with enable.
//             All-zero output when en_i is low.
//  Revision : 1.0  initial release
// ============================================================================
module idx2oh #(
    parameter int CW = 2,
    parameter int DW = 2 ** CW
) (
    input  logic [CW-1:0] idx_i,
    input  logic          en_i,
    output logic [DW-1:0] oh_o
);
    for (genvar i = 0; i < DW; i++) begin : g_bit
        assign oh_o[i] = en_i & (idx_i == CW'(i));
    end
endmodule
`default_nettype wire

// File: rtl/slot_freelist.sv
`default_nettype none
// ============================================================================
//  Module   : slot_freelist
//  Purpose  : Free-list allocator. Grants the lowest free slot as a binary
//             index, retires slots by index, flushes all slots at once.
//             Optional macro SLOT_FREELIST_ERRCHK_EN adds a sticky
//             double-free flag on err_o (tied low otherwise).
//  Revision : 1.0  initial release
// ============================================================================
module slot_freelist
    import slot_freelist_pkg::*;
#(
    parameter int CW = 2,
    parameter int DW = 2 ** CW
) (
    input  logic           CLK,
    input  logic           RSTn,
    slot_freelist_if.slave bus
);
    localparam int CNT_W = clog2(DW) + 1;

    // Reject slot counts outside the supported power-of-two range at elaboration.
    if ((DW < DW_MIN) || (DW > DW_MAX) || (DW != (1 << CW))) begin : g_bad_param
        $error("slot_freelist: DW must be 2**CW within [DW_MIN, DW_MAX]");
    end

    logic [DW-1:0]    busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    logic             w_grant;
    logic             w_free_hit;
    logic [CW-1:0]    w_alloc_idx;
    logic [DW-1:0]    w_set_oh;
    logic [DW-1:0]    w_clr_oh;

    // ------------------------------------------------------------------
    // Lowest-free search: balanced mux tree. Each level halves the node
    // count; a node carries "some slot below is free" plus the index of
    // the lowest such slot. Left child wins so the lowest index is kept.
    // The root merge is done outside the loop so every level is consumed.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < CW; l++) begin : g_lvl
        localparam int N = DW >> l;
        logic [N-1:0]  v;
        logic [CW-1:0] ix [N];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_slot
                assign v[i]  = ~busy_q[i];
                assign ix[i] = CW'(i);
            end
        end else begin : g_merge
            for (genvar j = 0; j < N; j++) begin : g_pair
                assign v[j]  = g_lvl[l-1].v[2*j] | g_lvl[l-1].v[2*j+1];
                assign ix[j] = g_lvl[l-1].v[2*j] ? g_lvl[l-1].ix[2*j]
                                                 : g_lvl[l-1].ix[2*j+1];
            end
        end
    end

    assign w_alloc_idx = g_lvl[CW-1].v[0] ? g_lvl[CW-1].ix[0] : g_lvl[CW-1].ix[1];

    assign bus.alloc_ready_o = ~full_q & ~bus.flush_i;
    assign bus.alloc_idx_o   = w_alloc_idx;
    assign w_grant           = bus.alloc_valid_i & bus.alloc_ready_o;

    idx2oh #(.CW(CW), .DW(DW)) u_set_dec (
        .idx_i (w_alloc_idx),
        .en_i  (w_grant),
        .oh_o  (w_set_oh)
    );

    idx2oh #(.CW(CW), .DW(DW)) u_clr_dec (
        .idx_i (bus.free_idx_i),
        .en_i  (bus.free_valid_i),
        .oh_o  (w_clr_oh)
    );

    // A free only counts when it targets a busy slot. A same-index grant
    // cannot coincide with a hit because the granted slot is free.
    assign w_free_hit = |(w_clr_oh & busy_q);

    // Next-state: flush clears everything; otherwise set-after-clear so a grant wins.
    always_comb begin
        busy_d = (busy_q & ~w_clr_oh) | w_set_oh;
        cnt_d  = cnt_q + CNT_W'(w_grant) - CNT_W'(w_free_hit);
        if (bus.flush_i) begin
            busy_d = '0;
            cnt_d  = '0;
        end
        full_d  = &busy_d;
        empty_d = ~|busy_d;
    end

    // Status and occupancy registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            busy_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.cnt_o   = cnt_q;
    assign bus.full_o  = full_q;
    assign bus.empty_o = empty_q;

`ifdef SLOT_FREELIST_ERRCHK_EN
    logic err_q, err_d;

    // Double-free detect: a non-flush free that hits no busy slot.
    always_comb begin
        err_d = err_q | (bus.free_valid_i & ~bus.flush_i & ~w_free_hit);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slot_freelist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slot_freelist
//  Purpose  : Scoreboard bench for slot_freelist (CW=2, DW=4). The driver
//             pushes hand-computed expectations; a monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_slot_freelist;

`ifdef SLOT_FREELIST_ERRCHK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        int         tag;
        logic [3:0] busy;
        logic [2:0] cnt;
        logic       rdy;
        logic [1:0] idx;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   tag_n;
    exp_t sb[$];
    event chk_ev;

    slot_freelist_if #(.CW(2), .DW(4)) bus ();

    slot_freelist #(.CW(2), .DW(4)) u_dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, tag, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] eb, input logic [2:0] ec, input logic er,
                            input logic [1:0] ei, input logic ee);
        exp_t e;
        e.tag  = tag_n;
        e.busy = eb;
        e.cnt  = ec;
        e.rdy  = er;
        e.idx  = ei;
        e.err  = ee & ERR_ON;
        sb.push_back(e);
        tag_n++;
    endtask

    // One cycle of stimulus plus the expected state/outputs seen during it.
    task automatic cyc(input logic av, input logic fv, input logic [1:0] fi, input logic fl,
                       input logic [3:0] eb, input logic [2:0] ec, input logic er,
                       input logic [1:0] ei, input logic ee);
        @(posedge clk);
        #1;
        bus.alloc_valid_i = av;
        bus.free_valid_i  = fv;
        bus.free_idx_i    = fi;
        bus.flush_i       = fl;
        push_exp(eb, ec, er, ei, ee);
    endtask

    // Monitor: compares the oldest expectation against what the DUT presents.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk or chk_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("busy",  e.tag, 8'(bus.busy_o),        8'(e.busy));
                chk("cnt",   e.tag, 8'(bus.cnt_o),         8'(e.cnt));
                chk("full",  e.tag, 8'(bus.full_o),        8'(e.busy == 4'hF));
                chk("empty", e.tag, 8'(bus.empty_o),       8'(e.busy == 4'h0));
                chk("err",   e.tag, 8'(bus.err_o),         8'(e.err));
                chk("ready", e.tag, 8'(bus.alloc_ready_o), 8'(e.rdy));
                if (e.rdy) chk("idx", e.tag, 8'(bus.alloc_idx_o), 8'(e.idx));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        tag_n = 0;
        rst_n = 1'b0;
        bus.alloc_valid_i = 1'b0;
        bus.free_valid_i  = 1'b0;
        bus.free_idx_i    = 2'd0;
        bus.flush_i       = 1'b0;
        #12 rst_n = 1'b1;

        //   av fv fi  fl  busy     cnt rdy idx err
        cyc(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);   // reset state
        // fill from empty, lowest index first
        cyc(1, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 4'b0001, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 4'b0011, 2, 1, 2, 0);
        cyc(1, 0, 0, 0, 4'b0111, 3, 1, 3, 0);
        cyc(1, 0, 0, 0, 4'b1111, 4, 0, 0, 0);   // full: request ignored
        // free idx 2 alone, then re-grant it
        cyc(0, 1, 2, 0, 4'b1111, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 4'b1011, 3, 1, 2, 0);
        cyc(0, 0, 0, 0, 4'b1111, 4, 0, 0, 0);
        // flush to empty, rebuild 0011
        cyc(0, 0, 0, 1, 4'b1111, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 4'b0001, 1, 1, 1, 0);
        // alloc idx 2 with free idx 0 in the same cycle
        cyc(1, 1, 0, 0, 4'b0011, 2, 1, 2, 0);
        cyc(1, 0, 0, 0, 4'b0110, 2, 1, 0, 0);
        // flush with alloc and free present: both dropped
        cyc(1, 1, 1, 1, 4'b0111, 3, 0, 3, 0);
        cyc(1, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        // double free of idx 3 on 0001
        cyc(0, 1, 3, 0, 4'b0001, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 4'b0001, 1, 1, 1, 1);
        // alloc and double-free on the same index: set wins
        cyc(1, 1, 1, 0, 4'b0001, 1, 1, 1, 1);
        cyc(0, 1, 0, 0, 4'b0011, 2, 1, 2, 1);
        // build 1010
        cyc(1, 0, 0, 0, 4'b0010, 1, 1, 0, 1);
        cyc(1, 0, 0, 0, 4'b0011, 2, 1, 2, 1);
        cyc(1, 1, 0, 0, 4'b0111, 3, 1, 3, 1);
        cyc(0, 1, 2, 0, 4'b1110, 3, 1, 0, 1);
        cyc(0, 0, 0, 0, 4'b1010, 2, 1, 0, 1);

        // asynchronous reset in mid-cycle, checked before the next edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        push_exp(4'b0000, 0, 1, 0, 0);
        ->chk_ev;
        @(posedge clk);
        #1 rst_n = 1'b1;

        cyc(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 4'b0001, 1, 1, 1, 0);

        @(posedge clk);
        @(posedge clk);
        chk("drain", tag_n, 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
